// File: rtl/dport_phy_lanes.sv
// DisplayPort PHY lane mux: per-lane selection of scrambled data, TPS1, TPS2
// or PRBS7, restarted on every mode change, followed by a per-lane skew line.
//   dpclk   : link symbol clock (rising edge)
//   rst_n   : asynchronous active-low reset
//   phymode : requested mode (0 off, 1 data, 2 TPS1, 3 TPS2, 4 PRBS7, 5..7 off)
//   scrdat  : scrambled words, 16 bits per lane, lane i at [16i+15:16i]
//   scrisk  : K-flags for scrdat, 2 bits per lane
//   txdat   : words to the 8b/10b transceivers, same packing as scrdat
//   txisk   : K-flags to the transceivers
//   pat_sof : pulse with lane 0 output of TPS2 word 0
//   mode_q  : mode currently applied by the generator
module dport_phy_lanes #(
   parameter int unsigned NLANES = 2,
   parameter int unsigned SKEW   = 1
) (
   input  logic                   dpclk,
   input  logic                   rst_n,
   input  logic [2:0]             phymode,
   input  logic [16*NLANES-1:0]   scrdat,
   input  logic [2*NLANES-1:0]    scrisk,
   output logic [16*NLANES-1:0]   txdat,
   output logic [2*NLANES-1:0]    txisk,
   output logic                   pat_sof,
   output logic [2:0]             mode_q
);

   localparam int unsigned DW = 16 * NLANES;
   localparam int unsigned KW = 2 * NLANES;

   localparam logic [2:0] MODE_OFF  = 3'd0;
   localparam logic [2:0] MODE_DATA = 3'd1;
   localparam logic [2:0] MODE_TPS1 = 3'd2;
   localparam logic [2:0] MODE_TPS2 = 3'd3;
   localparam logic [2:0] MODE_PRBS = 3'd4;

   localparam logic [6:0]  PRBS_SEED = 7'h7F;
   localparam logic [15:0] W_D102    = 16'h4A4A;
   localparam logic [15:0] W_K285    = 16'hCBBC;

   logic [2:0]    mode_map_c;
   logic [2:0]    mode_d;
   logic [2:0]    ctr, ctr_d;
   logic [6:0]    prbs, prbs_d;
   logic [15:0]   prbs_word_c;
   logic [6:0]    prbs_nxt_c;
   logic [DW-1:0] gen_dat_c;
   logic [KW-1:0] gen_isk_c;
   logic          gen_sof_c;
   logic [DW-1:0] st0_dat;
   logic [KW-1:0] st0_isk;

   // Undefined mode codes collapse to off
   assign mode_map_c = (phymode > MODE_PRBS) ? MODE_OFF : phymode;

   // 16 serial PRBS7 steps per cycle; first generated bit lands in bit 0
   always_comb begin : prbs_walk
      logic [6:0] s;
      s           = prbs;
      prbs_word_c = '0;
      for (int b = 0; b < 16; b++) begin
         prbs_word_c[b] = s[6] ^ s[5];
         s              = {s[5:0], s[6] ^ s[5]};
      end
      prbs_nxt_c = s;
   end

   // Mode/sequencer state register
   always_ff @(posedge dpclk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= MODE_OFF;
         ctr    <= '0;
         prbs   <= PRBS_SEED;
      end else begin
         mode_q <= mode_d;
         ctr    <= ctr_d;
         prbs   <= prbs_d;
      end
   end

   // Next state: a mode change restarts both sequences, otherwise they free-run
   always_comb begin
      mode_d = mode_q;
      ctr_d  = (ctr == 3'd4) ? 3'd0 : ctr + 3'd1;
      prbs_d = prbs_nxt_c;
      if (mode_map_c != mode_q) begin
         mode_d = mode_map_c;
         ctr_d  = '0;
         prbs_d = PRBS_SEED;
      end
   end

   // Pattern generator; TPS2 is K28.5 D11.6 for two cycles then D10.2 for three
   always_comb begin
      gen_dat_c = '0;
      gen_isk_c = '0;
      gen_sof_c = 1'b0;
      case (mode_q)
         MODE_DATA: begin
            gen_dat_c = scrdat;
            gen_isk_c = scrisk;
         end
         MODE_TPS1: gen_dat_c = {NLANES{W_D102}};
         MODE_TPS2: begin
            gen_sof_c = (ctr == 3'd0);
            if (ctr < 3'd2) begin
               gen_dat_c = {NLANES{W_K285}};
               gen_isk_c = {NLANES{2'b01}};
            end else begin
               gen_dat_c = {NLANES{W_D102}};
            end
         end
         MODE_PRBS: gen_dat_c = {NLANES{prbs_word_c}};
         default: ;
      endcase
   end

   // Common output stage; pat_sof travels with lane 0
   always_ff @(posedge dpclk or negedge rst_n) begin
      if (!rst_n) begin
         st0_dat <= '0;
         st0_isk <= '0;
         pat_sof <= 1'b0;
      end else begin
         st0_dat <= gen_dat_c;
         st0_isk <= gen_isk_c;
         pat_sof <= gen_sof_c;
      end
   end

   // Per-lane skew line of i*SKEW stages; always shifting so old words drain first
   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      localparam int unsigned DEPTH = 32'(i) * SKEW;
      if (DEPTH == 0) begin : g_direct
         assign txdat[16*i +: 16] = st0_dat[16*i +: 16];
         assign txisk[2*i +: 2]   = st0_isk[2*i +: 2];
      end else begin : g_skew
         logic [17:0] pipe [DEPTH];
         always_ff @(posedge dpclk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned k = 0; k < DEPTH; k++) pipe[k] <= '0;
            end else begin
               pipe[0] <= {st0_isk[2*i +: 2], st0_dat[16*i +: 16]};
               for (int unsigned k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
            end
         end
         assign {txisk[2*i +: 2], txdat[16*i +: 16]} = pipe[DEPTH-1];
      end
   end

endmodule

// File: tb/tb_dport_phy_lanes.sv
// Scoreboard bench for dport_phy_lanes: one instance with 2 lanes/skew 1 and
// one with 4 lanes/skew 2, driven from the same stimulus and checked against
// a cycle model whose outputs are queued per lane and popped as the DUT emits.
module tb_dport_phy_lanes;

   localparam int unsigned SKA = 1;
   localparam int unsigned SKB = 2;

   logic        dpclk;
   logic        rst_n;
   logic [2:0]  phymode;
   logic [63:0] scrdat;
   logic [7:0]  scrisk;

   logic [31:0] txdat_a;
   logic [3:0]  txisk_a;
   logic        pat_sof_a;
   logic [2:0]  mode_q_a;
   logic [63:0] txdat_b;
   logic [7:0]  txisk_b;
   logic        pat_sof_b;
   logic [2:0]  mode_q_b;

   dport_phy_lanes #(.NLANES(2), .SKEW(SKA)) u_a (
      .dpclk   (dpclk),
      .rst_n   (rst_n),
      .phymode (phymode),
      .scrdat  (scrdat[31:0]),
      .scrisk  (scrisk[3:0]),
      .txdat   (txdat_a),
      .txisk   (txisk_a),
      .pat_sof (pat_sof_a),
      .mode_q  (mode_q_a)
   );

   dport_phy_lanes #(.NLANES(4), .SKEW(SKB)) u_b (
      .dpclk   (dpclk),
      .rst_n   (rst_n),
      .phymode (phymode),
      .scrdat  (scrdat),
      .scrisk  (scrisk),
      .txdat   (txdat_b),
      .txisk   (txisk_b),
      .pat_sof (pat_sof_b),
      .mode_q  (mode_q_b)
   );

   always #5 dpclk = ~dpclk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [2:0] m_mode;
   int         m_ctr;
   logic [6:0] m_prbs;

   logic [17:0] qa [2][$];
   logic [17:0] qb [4][$];
   logic        sq [$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] prbs_word(input logic [6:0] seed);
      logic [6:0]  s;
      logic [15:0] w;
      s = seed;
      w = '0;
      for (int b = 0; b < 16; b++) begin
         w[b] = s[6] ^ s[5];
         s    = {s[5:0], w[b]};
      end
      return w;
   endfunction

   function automatic logic [6:0] prbs_adv(input logic [6:0] seed);
      logic [6:0] s;
      s = seed;
      for (int b = 0; b < 16; b++) s = {s[5:0], s[6] ^ s[5]};
      return s;
   endfunction

   task automatic model_gen(output logic [63:0] d, output logic [7:0] k, output logic sof);
      logic [15:0] w;
      logic [1:0]  wk;
      d   = '0;
      k   = '0;
      sof = 1'b0;
      w   = '0;
      wk  = '0;
      if (m_mode == 3'd1) begin
         d = scrdat;
         k = scrisk;
      end else if (m_mode >= 3'd2 && m_mode <= 3'd4) begin
         if (m_mode == 3'd2) w = 16'h4A4A;
         else if (m_mode == 3'd3) begin
            sof = (m_ctr == 0);
            if (m_ctr < 2) begin
               w  = 16'hCBBC;
               wk = 2'b01;
            end else w = 16'h4A4A;
         end else w = prbs_word(m_prbs);
         d = {4{w}};
         k = {4{wk}};
      end
   endtask

   task automatic model_adv();
      logic [2:0] mp;
      mp = (phymode > 3'd4) ? 3'd0 : phymode;
      if (mp != m_mode) begin
         m_mode = mp;
         m_ctr  = 0;
         m_prbs = 7'h7F;
      end else begin
         m_ctr  = (m_ctr + 1) % 5;
         m_prbs = prbs_adv(m_prbs);
      end
   endtask

   task automatic new_data();
      scrdat = {$urandom, $urandom};
      scrisk = 8'($urandom);
   endtask

   // One clock: queue expectation from current inputs, clock, compare DUT outputs
   task automatic step();
      logic [63:0] d;
      logic [7:0]  k;
      logic        sof;
      logic [17:0] e;
      logic        es;
      model_gen(d, k, sof);
      for (int l = 0; l < 2; l++) qa[l].push_back({k[2*l +: 2], d[16*l +: 16]});
      for (int l = 0; l < 4; l++) qb[l].push_back({k[2*l +: 2], d[16*l +: 16]});
      sq.push_back(sof);
      @(posedge dpclk);
      model_adv();
      #1;
      for (int l = 0; l < 2; l++) begin
         e = '1;
         if (qa[l].size() != 0) e = qa[l].pop_front();
         check_eq($sformatf("a_lane%0d", l), 64'({txisk_a[2*l +: 2], txdat_a[16*l +: 16]}), 64'(e));
      end
      for (int l = 0; l < 4; l++) begin
         e = '1;
         if (qb[l].size() != 0) e = qb[l].pop_front();
         check_eq($sformatf("b_lane%0d", l), 64'({txisk_b[2*l +: 2], txdat_b[16*l +: 16]}), 64'(e));
      end
      es = 1'bx;
      if (sq.size() != 0) es = sq.pop_front();
      check_eq("a_sof", 64'(pat_sof_a), 64'(es));
      check_eq("b_sof", 64'(pat_sof_b), 64'(es));
      check_eq("a_mode", 64'(mode_q_a), 64'(m_mode));
      check_eq("b_mode", 64'(mode_q_b), 64'(m_mode));
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_a"}, 64'({mode_q_a, pat_sof_a, txisk_a, txdat_a}), 64'(0));
      check_eq({tag, "_b"}, {txdat_b}, 64'(0));
      check_eq({tag, "_b_ctl"}, 64'({mode_q_b, pat_sof_b, txisk_b}), 64'(0));
   endtask

   // Asserts reset (cleared immediately), holds it, then restarts the model
   task automatic do_reset(input logic [2:0] pm);
      phymode = pm;
      new_data();
      rst_n = 1'b0;
      #1;
      check_zero("rst_async");
      repeat (3) begin
         @(posedge dpclk);
         #1;
         new_data();
         check_zero("rst_hold");
      end
      m_mode = 3'd0;
      m_ctr  = 0;
      m_prbs = 7'h7F;
      for (int l = 0; l < 2; l++) begin
         qa[l].delete();
         repeat (l * SKA) qa[l].push_back(18'h0);
      end
      for (int l = 0; l < 4; l++) begin
         qb[l].delete();
         repeat (l * SKB) qb[l].push_back(18'h0);
      end
      sq.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      dpclk   = 1'b0;
      rst_n   = 1'b1;
      phymode = 3'd0;
      scrdat  = '0;
      scrisk  = '0;
      #2;

      // Reset with data mode requested, then random data through both lane sets
      do_reset(3'd1);
      repeat (20) begin new_data(); step(); end

      // TPS1
      phymode = 3'd2;
      repeat (10) begin new_data(); step(); end
      check_eq("tps1_word", 64'(txdat_a), 64'(32'h4A4A4A4A));

      // Off, then TPS2 from a clean start
      phymode = 3'd0;
      repeat (8) begin new_data(); step(); end
      phymode = 3'd3;
      step();
      step();
      check_eq("tps2_first", 64'({txisk_a[1:0], txdat_a[15:0]}), 64'({2'b01, 16'hCBBC}));
      check_eq("tps2_sof", 64'(pat_sof_a), 64'(1));
      repeat (20) begin new_data(); step(); end

      // PRBS7 after reset: known first word, then long run against the model
      do_reset(3'd4);
      step();
      step();
      check_eq("prbs_first", 64'(txdat_a[15:0]), 64'(16'h3040));
      repeat (1000) step();

      // Reset mid-stream
      do_reset(3'd1);
      repeat (6) begin new_data(); step(); end

      // TPS2 interrupted at ctr 3 by TPS1, then resumed from the period start
      phymode = 3'd3;
      for (int i = 0; i < 12 && m_ctr != 3; i++) step();
      check_eq("tps2_ctr3_reached", 64'(m_ctr), 64'(3));
      phymode = 3'd2;
      step();
      step();
      phymode = 3'd3;
      step();
      step();
      check_eq("tps2_restart", 64'({txisk_a[1:0], txdat_a[15:0]}), 64'({2'b01, 16'hCBBC}));
      repeat (15) step();

      // Data on all lanes, then an undefined mode code drains to zero
      phymode = 3'd1;
      repeat (12) begin new_data(); step(); end
      phymode = 3'd6;
      repeat (10) begin new_data(); step(); end
      check_eq("mode6_mode_b", 64'(mode_q_b), 64'(0));
      check_eq("mode6_dat_b", txdat_b, 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
